// File: rtl/pong_game_ctrl.sv
// Ping-pong game sequencer: keyboard-held paddles, per-frame ball physics, scoring and
// serve/win sequencing. All outputs are registers feeding the pixel renderer.
module pong_game_ctrl #(
    parameter int SCREEN_W     = 640,
    parameter int SCREEN_H     = 480,
    parameter int PADDLE_H     = 64,
    parameter int PADDLE_W     = 8,
    parameter int PADDLE_X_L   = 16,
    parameter int PADDLE_X_R   = 616,
    parameter int PADDLE_STEP  = 4,
    parameter int BALL_SIZE    = 8,
    parameter int BALL_SPEED   = 2,
    parameter int SERVE_FRAMES = 60,
    parameter int WIN_SCORE    = 9
) (
    input  logic       clk25,
    input  logic       reset,
    input  logic [7:0] kb_code,
    input  logic       kb_break,
    input  logic       kb_strobe,
    input  logic       frame_tick,
    output logic [9:0] paddle_l_y,
    output logic [9:0] paddle_r_y,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic [3:0] score_l,
    output logic [3:0] score_r,
    output logic [2:0] game_state,
    output logic       winner
);
    // state     | meaning
    // S_IDLE    | waiting for space to start a match
    // S_SERVE   | ball parked at centre for SERVE_FRAMES frames
    // S_PLAY    | ball in motion, paddle hits and misses evaluated
    // S_SCORE   | one-frame pause after a miss
    // S_OVER    | match won, outputs frozen until space
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SERVE = 3'd1,
        S_PLAY  = 3'd2,
        S_SCORE = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    localparam int CW = $clog2(SERVE_FRAMES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(SERVE_FRAMES - 1);
    localparam logic [9:0] STEP    = 10'(PADDLE_STEP);
    localparam logic [9:0] PAD_MAX = 10'(SCREEN_H - PADDLE_H);
    localparam logic [9:0] PAD_H   = 10'(PADDLE_H);
    localparam logic [9:0] PAD_MID = 10'((SCREEN_H - PADDLE_H) / 2);
    localparam logic [9:0] SPEED   = 10'(BALL_SPEED);
    localparam logic [9:0] SIZE    = 10'(BALL_SIZE);
    localparam logic [9:0] CTR_X   = 10'((SCREEN_W - BALL_SIZE) / 2);
    localparam logic [9:0] CTR_Y   = 10'((SCREEN_H - BALL_SIZE) / 2);
    localparam logic [9:0] BOT_Y   = 10'(SCREEN_H - BALL_SIZE);
    localparam logic [9:0] SCR_H   = 10'(SCREEN_H);
    localparam logic [9:0] RGT_X   = 10'(SCREEN_W - BALL_SIZE);
    localparam logic [9:0] FACE_L  = 10'(PADDLE_X_L + PADDLE_W);
    localparam logic [9:0] FACE_R  = 10'(PADDLE_X_R - BALL_SIZE);
    localparam logic [3:0] WIN     = 4'(WIN_SCORE);

    state_t          state, state_nxt;
    logic [3:0]      held, held_nxt;
    logic            dx_pos, dx_nxt, dy_pos, dy_nxt;
    logic [CW-1:0]   serve_cnt, cnt_nxt;
    logic [9:0]      pl_nxt, pr_nxt, bx_nxt, by_nxt;
    logic [3:0]      sl_nxt, sr_nxt;
    logic            winner_nxt;
    logic [9:0]      y_mv, x_mv;
    logic            dy_mv, dx_mv, miss_l, miss_r, ov_l, ov_r;
    logic            space_make;

    function automatic logic [9:0] move_pad(input logic [9:0] y, input logic up, input logic dn);
        if (up && !dn)
            return (y >= STEP) ? y - STEP : 10'd0;
        else if (dn && !up)
            return (y + STEP > PAD_MAX) ? PAD_MAX : y + STEP;
        else
            return y;
    endfunction

    assign space_make = kb_strobe && !kb_break && (kb_code == 8'h29);
    assign game_state = state;

    // held bits: 0 W (left up), 1 S (left down), 2 O (right up), 3 L (right down)
    always_comb begin
        held_nxt = held;
        if (kb_strobe) begin
            case (kb_code)
                8'h1D:   held_nxt[0] = ~kb_break;
                8'h1B:   held_nxt[1] = ~kb_break;
                8'h44:   held_nxt[2] = ~kb_break;
                8'h4B:   held_nxt[3] = ~kb_break;
                default: held_nxt = held;
            endcase
        end
    end

    // Ball physics against pre-update paddle positions; paddle faces take priority over misses.
    always_comb begin
        y_mv   = ball_y;
        dy_mv  = dy_pos;
        x_mv   = ball_x;
        dx_mv  = dx_pos;
        miss_l = 1'b0;
        miss_r = 1'b0;
        ov_l   = (ball_y + SIZE > paddle_l_y) && (ball_y < paddle_l_y + PAD_H);
        ov_r   = (ball_y + SIZE > paddle_r_y) && (ball_y < paddle_r_y + PAD_H);
        if (!dy_pos) begin
            if (ball_y <= SPEED) begin
                y_mv  = 10'd0;
                dy_mv = 1'b1;
            end else begin
                y_mv = ball_y - SPEED;
            end
        end else if (ball_y + SIZE + SPEED >= SCR_H) begin
            y_mv  = BOT_Y;
            dy_mv = 1'b0;
        end else begin
            y_mv = ball_y + SPEED;
        end
        if (!dx_pos) begin
            if (ball_x >= FACE_L && ball_x - SPEED < FACE_L && ov_l) begin
                x_mv  = FACE_L;
                dx_mv = 1'b1;
            end else if (ball_x < SPEED) begin
                miss_r = 1'b1;
            end else begin
                x_mv = ball_x - SPEED;
            end
        end else begin
            if (ball_x <= FACE_R && ball_x + SPEED > FACE_R && ov_r) begin
                x_mv  = FACE_R;
                dx_mv = 1'b0;
            end else if (ball_x + SPEED > RGT_X) begin
                miss_l = 1'b1;
            end else begin
                x_mv = ball_x + SPEED;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        pl_nxt     = paddle_l_y;
        pr_nxt     = paddle_r_y;
        bx_nxt     = ball_x;
        by_nxt     = ball_y;
        dx_nxt     = dx_pos;
        dy_nxt     = dy_pos;
        sl_nxt     = score_l;
        sr_nxt     = score_r;
        cnt_nxt    = serve_cnt;
        winner_nxt = winner;
        if (frame_tick && (state == S_SERVE || state == S_PLAY)) begin
            pl_nxt = move_pad(paddle_l_y, held[0], held[1]);
            pr_nxt = move_pad(paddle_r_y, held[2], held[3]);
        end
        case (state)
            S_IDLE: begin
                if (space_make) begin
                    state_nxt = S_SERVE;
                    sl_nxt    = 4'd0;
                    sr_nxt    = 4'd0;
                    bx_nxt    = CTR_X;
                    by_nxt    = CTR_Y;
                    dx_nxt    = 1'b1;
                    cnt_nxt   = '0;
                end
            end
            S_SERVE: begin
                if (frame_tick) begin
                    bx_nxt = CTR_X;
                    by_nxt = CTR_Y;
                    if (serve_cnt == CNT_LAST) begin
                        state_nxt = S_PLAY;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = serve_cnt + 1'b1;
                    end
                end
            end
            S_PLAY: begin
                if (frame_tick) begin
                    if (miss_l) begin
                        sl_nxt    = (score_l >= WIN) ? WIN : score_l + 4'd1;
                        dx_nxt    = 1'b1;
                        state_nxt = S_SCORE;
                    end else if (miss_r) begin
                        sr_nxt    = (score_r >= WIN) ? WIN : score_r + 4'd1;
                        dx_nxt    = 1'b0;
                        state_nxt = S_SCORE;
                    end else begin
                        bx_nxt = x_mv;
                        by_nxt = y_mv;
                        dx_nxt = dx_mv;
                        dy_nxt = dy_mv;
                    end
                end
            end
            S_SCORE: begin
                if (frame_tick) begin
                    if (score_l == WIN || score_r == WIN) begin
                        state_nxt  = S_OVER;
                        winner_nxt = (score_r == WIN);
                    end else begin
                        state_nxt = S_SERVE;
                        bx_nxt    = CTR_X;
                        by_nxt    = CTR_Y;
                        dy_nxt    = 1'b1;
                    end
                end
            end
            S_OVER: begin
                if (space_make)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk25 or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            held       <= 4'd0;
            paddle_l_y <= PAD_MID;
            paddle_r_y <= PAD_MID;
            ball_x     <= CTR_X;
            ball_y     <= CTR_Y;
            dx_pos     <= 1'b1;
            dy_pos     <= 1'b1;
            score_l    <= 4'd0;
            score_r    <= 4'd0;
            serve_cnt  <= '0;
            winner     <= 1'b0;
        end else begin
            state      <= state_nxt;
            held       <= held_nxt;
            paddle_l_y <= pl_nxt;
            paddle_r_y <= pr_nxt;
            ball_x     <= bx_nxt;
            ball_y     <= by_nxt;
            dx_pos     <= dx_nxt;
            dy_pos     <= dy_nxt;
            score_l    <= sl_nxt;
            score_r    <= sr_nxt;
            serve_cnt  <= cnt_nxt;
            winner     <= winner_nxt;
        end
    end

endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
Game sequencer for the VGA ping-pong design. It consumes decoded PS/2 scancodes (code, break flag, strobe) and a once-per-frame tick from the sync generator. It runs the game state machine and updates paddle positions, ball position/direction and scores once per frame. Its registered outputs feed the pixel renderer.

Parameters:
SCREEN_W, 640, active width in pixels
SCREEN_H, 480, active height in pixels
PADDLE_H, 64, paddle height
PADDLE_W, 8, paddle width
PADDLE_X_L, 16, left paddle left edge x
PADDLE_X_R, 616, right paddle left edge x
PADDLE_STEP, 4, paddle move per frame
BALL_SIZE, 8, ball side length
BALL_SPEED, 2, ball move per frame per axis
SERVE_FRAMES, 60, frames the ball is held before play
WIN_SCORE, 9, winning score (≤15)

Ports:
clk25  in  1  pixel clock; only clock
reset  in  1  asynchronous, active-low reset
kb_code  in  8  scancode byte from keyboard decoder
kb_break  in  1  1 = release (break) code, qualified by kb_strobe
kb_strobe  in  1  one-cycle pulse, kb_code/kb_break valid (clk25 domain)
frame_tick  in  1  one-cycle pulse per frame
paddle_l_y  out  10  left paddle top y
paddle_r_y  out  10  right paddle top y
ball_x  out  10  ball left x
ball_y  out  10  ball top y
score_l  out  4  left score
score_r  out  4  right score
game_state  out  3  0 IDLE, 1 SERVE, 2 PLAY, 3 SCORE, 4 GAME_OVER
winner  out  1  0 left, 1 right; valid in GAME_OVER

Behaviour:
- Reset (async, reset=0): paddles 208, ball (316,236), scores 0, state IDLE, winner 0, held keys cleared, dx=+, dy=+, serve counter 0.
- Keys on kb_strobe: W 0x1D (left up), S 0x1B (left down), O 0x44 (right up), L 0x4B (right down). For these, held[k] <= ~kb_break.
- Space 0x29 make (kb_break=0) is a start event. Space break and all other codes are ignored.
- All updates are registered and visible the cycle after frame_tick. A kb_strobe coinciding with frame_tick updates held[] on the same edge. Movement on that edge uses the previous held[] value.
- Paddle move, on frame_tick in SERVE and PLAY only:
  - up-only: y = (y ≥ STEP) ? y−STEP : 0
  - down-only: y = min(y+STEP, SCREEN_H−PADDLE_H)
  - both or none held: no change
- IDLE: on space make → SERVE; scores cleared, ball centred, dx=+.
- SERVE: ball held at centre. Counter increments per frame_tick. After SERVE_FRAMES ticks → PLAY, counter cleared.
- PLAY, on each frame_tick, vertical motion:
  - dy=− and y ≤ SPEED → y=0, dy=+
  - dy=+ and y+BALL_SIZE+SPEED ≥ SCREEN_H → y=SCREEN_H−BALL_SIZE, dy=−
  - otherwise y ± SPEED
- PLAY horizontal motion, left face FL = PADDLE_X_L+PADDLE_W (24), right face FR = PADDLE_X_R−BALL_SIZE (608):
  - Overlap means ball_y+BALL_SIZE > pad_y and ball_y < pad_y+PADDLE_H, using pre-update paddle values.
  - dx=−, x ≥ FL, x−SPEED < FL, overlap → x=FL, dx=+
  - dx=+, x ≤ FR, x+SPEED > FR, overlap → x=FR, dx=−
  - dx=−, x < SPEED → miss: score_r+1, next serve dx=−, → SCORE, ball frozen
  - dx=+, x+SPEED > SCREEN_W−BALL_SIZE → miss: score_l+1, next serve dx=+, → SCORE, ball frozen
  - otherwise x ± SPEED
  - Vertical and horizontal results apply on the same tick. A vertical update is discarded on a miss tick.
- SCORE: on next frame_tick:
  - if a score = WIN_SCORE → GAME_OVER, winner set
  - else → SERVE with ball centred, dy=+
- Scores saturate at WIN_SCORE.
- GAME_OVER: outputs frozen. Space make → IDLE.
- Space in SERVE, PLAY or SCORE is ignored.
- Reset mid-game returns immediately to the reset values.
- Unsigned 10-bit arithmetic throughout; clamps prevent wrap.

Test Plan:
1. Reset low mid-PLAY → next observation: paddles 208/208, ball (316,236), scores 0, state 0, winner 0.
2. Space make in IDLE → state 1. After 60 frame_ticks → state 2. First PLAY tick → ball (318,238).
3. W make, 3 frame_ticks → paddle_l_y 196. W break, 2 ticks → 196. Both W and S held → unchanged. S held 110 ticks → clamps at 416, never 417+.
4. Right paddle held at 416 from serve. Ball reaches x=608 on the 146th PLAY tick with y=416 (bottom bounce at tick 118, y=472). Result: ball_x stays 608, dx negative, next tick ball_x=606.
5. Right paddle held at 0, same serve → no hit. On the tick where pre-update ball_x=632: score_l=1, state 3. Next tick → state 1 with ball (316,236).
6. WIN_SCORE=2, right paddle parked at 0, two right-side misses → state 4, winner=0, score_l=2. Space make → state 0. Next space → scores 0, state 1.
